// File: rtl/npu_inst_fetch.sv
// npu_inst_fetch: walks a PC through a 1-cycle instruction SRAM and streams {pc, inst} to the decoder
//   ports: clk, rst_n (async low) | start/start_pc begin fetch | redirect_valid/redirect_pc flush+restart
//          sram_addr -> SRAM, sram_q <- SRAM | inst_valid/inst_ready/inst_data/inst_pc to decoder
//          busy (not idle), done (HALT delivered, pipe empty), stall_cycles (perf counter)
//   NPU_FETCH_PERF_EN: when defined, stall_cycles counts busy cycles with nothing to offer (saturating)
module npu_inst_fetch #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int FIFO_DEPTH = 2,
  parameter logic [3:0] HALT_OPC = 4'h8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_q,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);
  localparam int PW = FIFO_DEPTH > 2 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc, pend_pc;
  logic pending;
  logic [DATA_W-1:0] buf_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] buf_pc [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic redir, pop, push, issue, halt_cap, drained;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign sram_addr = pc;
  assign inst_valid = count != '0;
  assign inst_data = inst_valid ? buf_data[rd_ptr] : '0;
  assign inst_pc = inst_valid ? buf_pc[rd_ptr] : '0;
  always_comb begin
    redir = redirect_valid & (state != IDLE);
    pop = inst_valid & inst_ready;
    push = pending & (state == FETCH) & ~redir;
    // a slot freed by this edge's pop counts as free, so a steady ready stream sustains one per cycle
    issue = (state == FETCH) & ~redir & (int'(count) + int'(pending) - int'(pop) < FIFO_DEPTH);
    halt_cap = push & (sram_q[DATA_W-1 -: 4] == HALT_OPC);
    // nothing is captured in DRAIN, so the pipe is empty once the last entry pops
    drained = (state == DRAIN) & ~redir & (int'(count) == int'(pop));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      pend_pc <= '0;
      pending <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (redir) begin
        state <= FETCH;
        busy <= 1'b1;
        pc <= redirect_pc;
        pending <= 1'b0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (state == IDLE && start) begin
          state <= FETCH;
          busy <= 1'b1;
          pc <= start_pc;
        end
        if (issue) begin
          pc <= pc + ADDR_W'(1);
          pend_pc <= pc;
        end
        pending <= issue;
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop) rd_ptr <= nxt(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
        if (halt_cap) state <= DRAIN;
        if (drained) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= sram_q;
      buf_pc[wr_ptr] <= pend_pc;
    end
  end
`ifdef NPU_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (busy && !inst_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_npu_inst_fetch.sv
// tb_npu_inst_fetch: directed bench for npu_inst_fetch with a 1-cycle registered SRAM model
module tb_npu_inst_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [8:0] start_pc = '0;
  logic redirect_valid = 1'b0;
  logic [8:0] redirect_pc = '0;
  logic [8:0] sram_addr;
  logic [127:0] sram_q;
  logic inst_valid;
  logic inst_ready = 1'b0;
  logic [127:0] inst_data;
  logic [8:0] inst_pc;
  logic busy, done;
  logic [31:0] stall_cycles;
  logic [127:0] mem [512];
  int total = 0;
  int passed = 0;
  int fails = 0;
  npu_inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .sram_addr(sram_addr), .sram_q(sram_q), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  always @(posedge clk) sram_q <= mem[sram_addr];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] word(input logic [3:0] opc, input int k);
    return {opc, 92'h0, 32'(k)};
  endfunction
  task automatic do_start(input logic [8:0] spc);
    start_pc = spc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  localparam logic [31:0] STALL2 =
`ifdef NPU_FETCH_PERF_EN
    32'd2;
`else
    32'd0;
`endif
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = word(4'h1, i);
    #3;
    chk("rst_valid", 128'(inst_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_addr", 128'(sram_addr), 128'(0));
    chk("rst_data", inst_data, 128'(0));
    chk("rst_pc", 128'(inst_pc), 128'(0));
    chk("rst_stall", 128'(stall_cycles), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    // test 1: two-word program ending in HALT
    mem[0] = {32'h1000_2020, 96'h0};
    mem[1] = {32'h8000_1800, 96'h0};
    inst_ready = 1'b1;
    do_start(9'd0);
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_n0_valid", 128'(inst_valid), 128'(0));
    tick();
    chk("t1_n1_valid", 128'(inst_valid), 128'(0));
    chk("t1_n1_addr", 128'(sram_addr), 128'(1));
    tick();
    chk("t1_valid0", 128'(inst_valid), 128'(1));
    chk("t1_pc0", 128'(inst_pc), 128'(0));
    chk("t1_data0", inst_data, mem[0]);
    tick();
    chk("t1_valid1", 128'(inst_valid), 128'(1));
    chk("t1_pc1", 128'(inst_pc), 128'(1));
    chk("t1_data1", inst_data, mem[1]);
    tick();
    chk("t1_done", 128'(done), 128'(1));
    chk("t1_busy_low", 128'(busy), 128'(0));
    chk("t1_valid_low", 128'(inst_valid), 128'(0));
    chk("t1_stall", 128'(stall_cycles), 128'(STALL2));
    tick();
    chk("t1_done_pulse", 128'(done), 128'(0));
    // test 2: backpressure fills the buffer, then in-order release
    for (int i = 0; i < 8; i++) mem[i] = word(4'h1, 100 + i);
    mem[8] = word(4'h8, 108);
    inst_ready = 1'b0;
    do_start(9'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_full_valid", 128'(inst_valid), 128'(1));
    chk("t2_full_pc", 128'(inst_pc), 128'(0));
    chk("t2_addr_held", 128'(sram_addr), 128'(2));
    chk("t2_stall_full", 128'(stall_cycles), 128'(STALL2));
    inst_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t2_valid%0d", k), 128'(inst_valid), 128'(1));
      chk($sformatf("t2_pc%0d", k), 128'(inst_pc), 128'(k));
      chk($sformatf("t2_data%0d", k), inst_data, mem[k]);
      tick();
    end
    chk("t2_done", 128'(done), 128'(1));
    chk("t2_busy", 128'(busy), 128'(0));
    // test 3: PC wraps 511 -> 0
    mem[510] = word(4'h2, 510);
    mem[511] = word(4'h3, 511);
    mem[0] = word(4'h8, 0);
    do_start(9'd510);
    tick();
    chk("t3_addr511", 128'(sram_addr), 128'(511));
    tick();
    chk("t3_addr_wrap", 128'(sram_addr), 128'(0));
    chk("t3_pc510", 128'(inst_pc), 128'(510));
    chk("t3_data510", inst_data, mem[510]);
    tick();
    chk("t3_pc511", 128'(inst_pc), 128'(511));
    tick();
    chk("t3_pc0", 128'(inst_pc), 128'(0));
    chk("t3_data0", inst_data, mem[0]);
    tick();
    chk("t3_done", 128'(done), 128'(1));
    // test 4: redirect to 20 while head pc5 is accepted
    for (int i = 0; i < 22; i++) mem[i] = word(4'h1, 200 + i);
    mem[22] = word(4'h8, 222);
    do_start(9'd0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_pc%0d", k), 128'(inst_pc), 128'(k));
      tick();
    end
    chk("t4_pc5", 128'(inst_pc), 128'(5));
    redirect_valid = 1'b1;
    redirect_pc = 9'd20;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 128'(inst_valid), 128'(0));
    chk("t4_flush_addr", 128'(sram_addr), 128'(20));
    chk("t4_flush_busy", 128'(busy), 128'(1));
    tick();
    chk("t4_gap_valid", 128'(inst_valid), 128'(0));
    tick();
    chk("t4_valid20", 128'(inst_valid), 128'(1));
    chk("t4_pc20", 128'(inst_pc), 128'(20));
    chk("t4_data20", inst_data, mem[20]);
    tick();
    chk("t4_pc21", 128'(inst_pc), 128'(21));
    tick();
    chk("t4_pc22", 128'(inst_pc), 128'(22));
    tick();
    chk("t4_done", 128'(done), 128'(1));
    // test 5: asynchronous reset mid-stream
    do_start(9'd3);
    tick();
    tick();
    tick();
    chk("t5_streaming", 128'(inst_valid), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(inst_valid), 128'(0));
    chk("t5_rst_busy", 128'(busy), 128'(0));
    chk("t5_rst_done", 128'(done), 128'(0));
    chk("t5_rst_addr", 128'(sram_addr), 128'(0));
    chk("t5_rst_stall", 128'(stall_cycles), 128'(0));
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_post_valid", 128'(inst_valid), 128'(0));
    chk("t5_post_busy", 128'(busy), 128'(0));
    chk("t5_post_addr", 128'(sram_addr), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
